// File: rtl/led_colour_scheduler.sv
// Shared RGB status LED controller: round-robin arbitration between three
// requesters with a minimum grant tenure, and autonomous colour cycling when idle.
module led_colour_scheduler #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STEP_DIV    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [8:0] req_colour,
  input  logic       auto_en,
  output logic [2:0] gnt,
  output logic [2:0] colour,
  output logic       busy
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES);
  localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, SERVE, AUTO} state_t;

  state_t        state, state_n;
  logic [2:0]    gnt_n, colour_n;
  logic [1:0]    rr_ptr, rr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [SW-1:0] step_cnt, step_n;

  logic [1:0] cand0, cand1, cand2, sel, gidx;
  logic [2:0] sel_colour;
  logic       hold_done, release_now;

  function automatic logic [2:0] legalise(input logic [2:0] c);
    return (c == 3'b000 || c == 3'b111) ? 3'b001 : c;
  endfunction

  // Round-robin scan order starts at rr_ptr and wraps modulo 3.
  always_comb begin
    cand0 = rr_ptr;
    cand1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    cand2 = (rr_ptr == 2'd0) ? 2'd2 : rr_ptr - 2'd1;
    if (req[cand0])      sel = cand0;
    else if (req[cand1]) sel = cand1;
    else                 sel = cand2;
    case (sel)
      2'd0:    sel_colour = req_colour[2:0];
      2'd1:    sel_colour = req_colour[5:3];
      default: sel_colour = req_colour[8:6];
    endcase
    gidx = gnt[1] ? 2'd1 : (gnt[2] ? 2'd2 : 2'd0);
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    colour_n    = colour;
    rr_n        = rr_ptr;
    hold_n      = hold_cnt;
    step_n      = step_cnt;
    hold_done   = (hold_cnt == HOLD_MAX);
    release_now = hold_done && (((req & gnt) == 3'b000) || ((req & ~gnt) != 3'b000));
    case (state)
      IDLE: begin
        if (|req) begin
          state_n  = SERVE;
          gnt_n    = 3'b001 << sel;
          colour_n = legalise(sel_colour);
          hold_n   = '0;
        end else if (auto_en) begin
          state_n = AUTO;
          step_n  = '0;
        end
      end
      SERVE: begin
        if (!hold_done) hold_n = hold_cnt + 1'b1;
        if (release_now) begin
          state_n = IDLE;
          gnt_n   = '0;
          rr_n    = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
        end
      end
      AUTO: begin
        if (|req || !auto_en) begin
          state_n = IDLE;
          step_n  = '0;
        end else if (step_cnt == STEP_MAX) begin
          step_n   = '0;
          colour_n = (colour == 3'b110) ? 3'b001 : colour + 3'd1;
        end else begin
          step_n = step_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      colour   <= 3'b001;
      busy     <= 1'b0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      colour   <= colour_n;
      busy     <= (state_n != IDLE);
      rr_ptr   <= rr_n;
      hold_cnt <= hold_n;
      step_cnt <= step_n;
    end
  end

endmodule
